hwpe_ctrl_uloop_stream: RTL and testbench

//  Parametrised microcode loop engine for HWPE controllers. Walks an NB_LOOPS-deep loop nest and runs a

---
 rtl/hwpe_ctrl_uloop_stream.sv | 199 +++++++++++++++++++
 tb/tb_hwpe_ctrl_uloop_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_uloop_stream.sv
// Microcode loop engine: walks an NB_LOOPS-deep loop nest, runs add/move microcode between
// points and streams {offsets, indices, loop, last} records through a FWFT buffer.
module hwpe_ctrl_uloop_stream #(
    parameter int unsigned LENGTH     = 32,
    parameter int unsigned NB_LOOPS   = 6,
    parameter int unsigned NB_REG     = 4,
    parameter int unsigned NB_RO_REG  = 28,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned PW = $clog2(LENGTH),
    localparam int unsigned LW = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1,
    localparam int unsigned AW = $clog2(NB_REG + NB_RO_REG)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            done_o,
    input  logic [LENGTH-1:0]               code_op_sel_i,
    input  logic [LENGTH*AW-1:0]            code_a_i,
    input  logic [LENGTH*AW-1:0]            code_b_i,
    input  logic [NB_LOOPS*PW-1:0]          loop_addr_i,
    input  logic [NB_LOOPS*(PW+1)-1:0]      loop_nb_ops_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]   loop_range_i,
    input  logic [NB_RO_REG*REG_WIDTH-1:0]  ro_reg_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [NB_REG*REG_WIDTH-1:0]     out_offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]   out_idx_o,
    output logic [LW-1:0]                   out_loop_o,
    output logic                            out_last_o
);

    typedef enum logic [1:0] {IDLE, PUSH, EXEC, DRAIN} state_e;

    localparam int unsigned OFFS_W = NB_REG * REG_WIDTH;
    localparam int unsigned IDX_W  = NB_LOOPS * CNT_WIDTH;
    localparam int unsigned ENT_W  = OFFS_W + IDX_W + LW + 1;
    localparam int unsigned FPW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW:0] CNT_ONE = 1;

    state_e               state;
    logic [REG_WIDTH-1:0] regs [NB_REG];
    logic [CNT_WIDTH-1:0] idx  [NB_LOOPS];
    logic [LW-1:0]        cur_loop;
    logic [PW-1:0]        pc;
    logic [PW:0]          cnt;

    logic [ENT_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0]     head;
    logic [FPW-1:0]       wr_ptr, rd_ptr;
    logic [FCW-1:0]       fifo_cnt;
    logic                 fifo_full, fifo_empty, push, pop;

    logic [CNT_WIDTH-1:0] idx_max [NB_LOOPS];
    logic                 is_last;
    logic [LW-1:0]        next_loop;
    logic [PW-1:0]        next_addr;
    logic [PW:0]          next_nb;
    logic [OFFS_W-1:0]    offs_flat;
    logic [IDX_W-1:0]     idx_flat;

    logic                 op_add;
    logic [AW-1:0]        op_a, op_b;
    logic [REG_WIDTH-1:0] src_val, dst_val, op_res;

    // Lowest level that still has iterations left is the one that advances next.
    always_comb begin
        is_last   = 1'b1;
        next_loop = '0;
        for (int l = NB_LOOPS - 1; l >= 0; l--) begin
            idx_max[l] = (loop_range_i[l*CNT_WIDTH +: CNT_WIDTH] == '0) ? '0 :
                         loop_range_i[l*CNT_WIDTH +: CNT_WIDTH] - 1'b1;
            if (idx[l] != idx_max[l]) is_last = 1'b0;
            if (idx[l] < idx_max[l])  next_loop = LW'(l);
        end
        next_addr = loop_addr_i[int'(next_loop)*PW +: PW];
        next_nb   = loop_nb_ops_i[int'(next_loop)*(PW+1) +: PW+1];
    end

    always_comb begin
        for (int r = 0; r < NB_REG; r++)   offs_flat[r*REG_WIDTH +: REG_WIDTH] = regs[r];
        for (int l = 0; l < NB_LOOPS; l++) idx_flat[l*CNT_WIDTH +: CNT_WIDTH] = idx[l];
    end

    // Operand fetch: writable regs first, then read-only regs; anything beyond reads 0.
    always_comb begin
        op_add  = code_op_sel_i[pc];
        op_a    = code_a_i[int'(pc)*AW +: AW];
        op_b    = code_b_i[int'(pc)*AW +: AW];
        src_val = '0;
        dst_val = '0;
        for (int r = 0; r < NB_REG; r++) begin
            if (op_b == AW'(r)) src_val = regs[r];
            if (op_a == AW'(r)) dst_val = regs[r];
        end
        for (int k = 0; k < NB_RO_REG; k++) begin
            if (op_b == AW'(NB_REG + k)) src_val = ro_reg_i[k*REG_WIDTH +: REG_WIDTH];
        end
        op_res = op_add ? dst_val + src_val : src_val;
    end

    assign fifo_full  = (fifo_cnt == FCW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = (state == PUSH) && !fifo_full;
    assign pop        = !fifo_empty && out_ready_i;
    assign busy_o     = (state != IDLE);

    function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
        return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cur_loop <= '0;
            pc       <= '0;
            cnt      <= '0;
            done_o   <= 1'b0;
            for (int r = 0; r < NB_REG; r++)   regs[r] <= '0;
            for (int l = 0; l < NB_LOOPS; l++) idx[l]  <= '0;
        end else if (clear_i) begin
            state    <= IDLE;
            cur_loop <= '0;
            pc       <= '0;
            cnt      <= '0;
            done_o   <= 1'b0;
            for (int r = 0; r < NB_REG; r++)   regs[r] <= '0;
            for (int l = 0; l < NB_LOOPS; l++) idx[l]  <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: if (start_i) begin
                    for (int r = 0; r < NB_REG; r++)   regs[r] <= '0;
                    for (int l = 0; l < NB_LOOPS; l++) idx[l]  <= '0;
                    cur_loop <= '0;
                    state    <= PUSH;
                end
                PUSH: if (!fifo_full) begin
                    if (is_last) begin
                        state <= DRAIN;
                    end else begin
                        for (int l = 0; l < NB_LOOPS; l++) begin
                            if (LW'(l) < next_loop)       idx[l] <= '0;
                            else if (LW'(l) == next_loop) idx[l] <= idx[l] + 1'b1;
                        end
                        cur_loop <= next_loop;
                        pc       <= next_addr;
                        cnt      <= next_nb;
                        state    <= (next_nb == '0) ? PUSH : EXEC;
                    end
                end
                EXEC: begin
                    for (int r = 0; r < NB_REG; r++) begin
                        if (op_a == AW'(r)) regs[r] <= op_res;
                    end
                    pc  <= (pc == PW'(LENGTH - 1)) ? '0 : pc + 1'b1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_ONE) state <= PUSH;
                end
                DRAIN: if (fifo_empty) begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= {offs_flat, idx_flat, cur_loop, is_last};
    end

    assign head        = fifo_mem[rd_ptr];
    assign out_valid_o = !fifo_empty;
    assign {out_offs_o, out_idx_o, out_loop_o, out_last_o} = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_stream.sv
// Directed bench for hwpe_ctrl_uloop_stream: a 2-level nest with 8-bit offsets so that
// wrap-around, back-pressure, clear and stray start pulses can all be exercised.
module tb_hwpe_ctrl_uloop_stream;
    localparam int LENGTH = 32, NB_LOOPS = 2, NB_REG = 4, NB_RO_REG = 28;
    localparam int REG_WIDTH = 8, CNT_WIDTH = 16, FIFO_DEPTH = 2;
    localparam int PW = 5, LW = 1, AW = 5;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic busy, done, out_valid, out_last;
    logic [LENGTH-1:0]               code_op_sel = '0;
    logic [LENGTH*AW-1:0]            code_a = '0, code_b = '0;
    logic [NB_LOOPS*PW-1:0]          loop_addr = '0;
    logic [NB_LOOPS*(PW+1)-1:0]      loop_nb_ops = '0;
    logic [NB_LOOPS*CNT_WIDTH-1:0]   loop_range = '0;
    logic [NB_RO_REG*REG_WIDTH-1:0]  ro_reg = '0;
    logic [NB_REG*REG_WIDTH-1:0]     out_offs;
    logic [NB_LOOPS*CNT_WIDTH-1:0]   out_idx;
    logic [LW-1:0]                   out_loop;

    typedef struct {
        logic [REG_WIDTH-1:0] r0, r1;
        logic [CNT_WIDTH-1:0] i0, i1;
        logic                 lp, last;
    } vec_t;

    vec_t t1_vec [6];
    int n_vec = 0, n_err = 0, done_cnt = 0, cyc = 0, rdy_tick = 0;

    hwpe_ctrl_uloop_stream #(
        .LENGTH(LENGTH), .NB_LOOPS(NB_LOOPS), .NB_REG(NB_REG), .NB_RO_REG(NB_RO_REG),
        .REG_WIDTH(REG_WIDTH), .CNT_WIDTH(CNT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
        .busy_o(busy), .done_o(done),
        .code_op_sel_i(code_op_sel), .code_a_i(code_a), .code_b_i(code_b),
        .loop_addr_i(loop_addr), .loop_nb_ops_i(loop_nb_ops), .loop_range_i(loop_range),
        .ro_reg_i(ro_reg),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_offs_o(out_offs), .out_idx_o(out_idx), .out_loop_o(out_loop), .out_last_o(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r0, input int r1, input int i0, input int i1,
                                input int lp, input int last);
        vec_t v;
        v.r0 = REG_WIDTH'(r0);  v.r1 = REG_WIDTH'(r1);
        v.i0 = CNT_WIDTH'(i0);  v.i1 = CNT_WIDTH'(i1);
        v.lp = lp[0];           v.last = last[0];
        return v;
    endfunction

    // Waits (bounded) for the next accepted record and compares every field of it.
    task automatic expect_rec(input string name, input vec_t v, input bit stall, output int acc);
        bit got = 1'b0;
        acc = -1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            out_ready = stall ? rdy_tick[0] : 1'b1;
            rdy_tick++;
            if (out_valid && out_ready) begin
                got = 1'b1;
                acc = cyc;
                check({name, ".offs"}, out_offs, {16'h0, v.r1, v.r0});
                check({name, ".idx"},  out_idx,  {v.i1, v.i0});
                check({name, ".loop"}, out_loop, v.lp);
                check({name, ".last"}, out_last, v.last);
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no record, expected one within 300 cycles", name);
        end
    endtask

    task automatic set_slot(input int s, input bit add, input int a, input int b);
        code_op_sel[s]      = add;
        code_a[s*AW +: AW]  = AW'(a);
        code_b[s*AW +: AW]  = AW'(b);
    endtask

    task automatic set_loop(input int l, input int addr, input int nb, input int rng);
        loop_addr[l*PW +: PW]                    = PW'(addr);
        loop_nb_ops[l*(PW+1) +: PW+1]            = (PW+1)'(nb);
        loop_range[l*CNT_WIDTH +: CNT_WIDTH]     = CNT_WIDTH'(rng);
    endtask

    // range{3,2}; loop0: R0+=ro0(4); loop1: R1+=ro1(100), R0=ro2(0)
    task automatic prog_base();
        code_op_sel = '0; code_a = '0; code_b = '0;
        loop_addr = '0; loop_nb_ops = '0; loop_range = '0; ro_reg = '0;
        ro_reg[7:0]   = 8'd4;
        ro_reg[15:8]  = 8'd100;
        ro_reg[23:16] = 8'd0;
        set_slot(0, 1'b1, 0, NB_REG + 0);
        set_slot(1, 1'b1, 1, NB_REG + 1);
        set_slot(2, 1'b0, 0, NB_REG + 2);
        set_loop(0, 0, 1, 3);
        set_loop(1, 1, 2, 2);
    endtask

    task automatic pulse_start(output int c0);
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base);
        for (int c = 0; c < 20 && done_cnt == base; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({name, ".done_cnt"}, done_cnt - base, 1);
        check({name, ".busy_after"}, busy, 1'b0);
        check({name, ".valid_after"}, out_valid, 1'b0);
    endtask

    initial begin
        int c0, acc, acc0, base;

        t1_vec[0] = mk(0, 0,   0, 0, 0, 0);
        t1_vec[1] = mk(4, 0,   1, 0, 0, 0);
        t1_vec[2] = mk(8, 0,   2, 0, 0, 0);
        t1_vec[3] = mk(0, 100, 0, 1, 1, 0);
        t1_vec[4] = mk(4, 100, 1, 1, 0, 0);
        t1_vec[5] = mk(8, 100, 2, 1, 0, 1);

        // Reset state
        prog_base();
        repeat (3) @(negedge clk);
        check("reset.valid", out_valid, 1'b0);
        check("reset.busy",  busy,      1'b0);
        check("reset.done",  done,      1'b0);
        check("reset.offs",  out_offs,  '0);
        check("reset.idx",   out_idx,   '0);
        check("reset.loop_last", {out_loop, out_last}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.busy", busy, 1'b0);

        // Test 1: basic 3x2 nest, consumer always ready
        base = done_cnt;
        pulse_start(c0);
        check("t1.valid_t1", out_valid, 1'b0);
        check("t1.busy_t1",  busy,      1'b1);
        for (int i = 0; i < 6; i++) begin
            expect_rec($sformatf("t1.rec%0d", i), t1_vec[i], 1'b0, acc);
            if (i == 0) check("t1.latency", acc - c0, 2);
        end
        wait_done("t1", base);

        // Test 2: back-pressure for 50 cycles, then alternating ready
        out_ready = 1'b0;
        base = done_cnt;
        pulse_start(c0);
        repeat (50) @(negedge clk);
        check("t2.held_valid", out_valid, 1'b1);
        check("t2.held_busy",  busy,      1'b1);
        check("t2.held_nodone", done_cnt - base, 0);
        check("t2.held_head", {out_offs, out_idx, out_last}, '0);
        for (int i = 0; i < 6; i++)
            expect_rec($sformatf("t2.rec%0d", i), t1_vec[i], 1'b1, acc);
        wait_done("t2", base);

        // Test 3: zero ranges and empty bodies give a single last record
        out_ready = 1'b0;
        set_loop(0, 0, 0, 0);
        set_loop(1, 0, 0, 0);
        base = done_cnt;
        pulse_start(c0);
        repeat (5) @(negedge clk);
        check("t3.busy_before_pop", busy, 1'b1);
        check("t3.nodone_before_pop", done_cnt - base, 0);
        expect_rec("t3.rec0", mk(0, 0, 0, 0, 0, 1), 1'b0, acc);
        wait_done("t3", base);

        // Test 4: clear while record 2 sits at the head, then a full restart
        prog_base();
        base = done_cnt;
        pulse_start(c0);
        expect_rec("t4.rec0", t1_vec[0], 1'b0, acc);
        expect_rec("t4.rec1", t1_vec[1], 1'b0, acc);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
        check("t4.head_rec2", out_offs, {16'h0, 8'd0, 8'd8});
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t4.clr_valid", out_valid, 1'b0);
        check("t4.clr_busy",  busy,      1'b0);
        check("t4.clr_offs",  out_offs,  '0);
        repeat (10) @(negedge clk);
        check("t4.clr_nodone", done_cnt - base, 0);
        check("t4.clr_idle",   busy,            1'b0);
        base = done_cnt;
        pulse_start(c0);
        for (int i = 0; i < 6; i++)
            expect_rec($sformatf("t4.rec%0d_re", i), t1_vec[i], 1'b0, acc);
        wait_done("t4", base);

        // Test 5: 70 iterations of R0+=4 with 8-bit offsets (wraps at record 64)
        code_op_sel = '0; code_a = '0; code_b = '0;
        loop_addr = '0; loop_nb_ops = '0; loop_range = '0;
        set_slot(0, 1'b1, 0, NB_REG + 0);
        set_loop(0, 0, 1, 70);
        set_loop(1, 0, 0, 0);
        base = done_cnt;
        acc0 = 0;
        pulse_start(c0);
        for (int n = 0; n < 70; n++) begin
            expect_rec($sformatf("t5.rec%0d", n), mk(4 * n, 0, n, 0, 0, (n == 69) ? 1 : 0),
                       1'b0, acc);
            if (n == 0) begin
                acc0 = acc;
                check("t5.latency", acc - c0, 2);
            end
            if (n == 69) check("t5.span", acc - acc0, 138);
        end
        wait_done("t5", base);

        // Test 6: dropped write to a read-only index and a stray start pulse mid-run
        prog_base();
        set_slot(3, 1'b0, NB_REG, NB_REG + 1);
        set_loop(1, 1, 3, 2);
        base = done_cnt;
        pulse_start(c0);
        expect_rec("t6.rec0", t1_vec[0], 1'b0, acc);
        expect_rec("t6.rec1", t1_vec[1], 1'b0, acc);
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i < 6; i++)
            expect_rec($sformatf("t6.rec%0d", i), t1_vec[i], 1'b0, acc);
        wait_done("t6", base);
        repeat (5) @(negedge clk);
        check("t6.no_restart", busy, 1'b0);
        check("t6.single_done", done_cnt - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
